// File: rtl/core_pkg.sv
// Package core_pkg
//   Shared core definitions used by fetch and decode.
//   XLEN             : architectural register/address width
//   INSTR_NOP        : canonical NOP encoding (addi x0,x0,0)
//   DEFAULT_RESET_PC : byte address fetched first after reset
//   fetch_entry_t    : record handed from fetch to decode, {pc, instr}
//   word_index()     : byte PC -> instruction-memory word index
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  // The instruction memory is word addressed; the two byte-offset bits are dropped.
  function automatic logic [XLEN-1:0] word_index(input logic [XLEN-1:0] pc);
    return {2'b00, pc[XLEN-1:2]};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Module fetch_fifo
//   Synchronous FIFO buffering fetched entries in front of decode.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     push, data : write data into the tail
//     pop        : drop the head entry
//     flush      : empty the FIFO; overrides push and pop
//     count      : number of valid entries (0..DEPTH)
//     head       : entry at the head (meaningful only while !empty)
//     full/empty : occupancy flags
//   DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only observed after being written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Module instruction_fetch
//   Fetch stage in front of a 1-cycle-latency instruction memory. Holds the
//   PC, drives the memory port, captures the returned word and hands
//   {pc, instr} to decode through a small output FIFO.
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     redirect_valid/_pc   : flush everything fetched and restart at redirect_pc
//     imem_ce/we/addr/d    : memory port (read only; addr is a word index)
//     imem_q               : read data, valid the cycle after the address with ce high
//     out_valid/ready      : handshake to decode
//     out_pc/out_instr     : head entry
//     fetch_fault          : sticky misaligned-redirect fault
//   Handshake: an entry transfers on every rising clk edge where out_valid and
//   out_ready are both 1 (and no redirect is present); while out_valid=1 and
//   out_ready=0 the head (out_pc/out_instr) is held stable. out_valid never
//   depends on out_ready.
//   Build option: define FETCH_MISALIGN_CHK_EN to halt on a misaligned redirect
//   and raise fetch_fault until the next aligned redirect; otherwise the low two
//   redirect bits are ignored and fetch_fault is constant 0.
module instruction_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_ce,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_d,
  input  logic [31:0] imem_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int UW = CW + 1;

  logic [31:0]  pc_q;
  logic [31:0]  inflight_pc;
  logic         inflight_v;
  logic         halted;
  logic         misalign;
  logic [31:0]  redirect_target;
  logic         pop;
  logic         push;
  logic         issue;
  logic [UW-1:0] credit_used;
  logic [CW-1:0] fifo_count;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic         unused_bits;

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_q;

  assign misalign        = (redirect_pc[1:0] != 2'b00);
  assign redirect_target = redirect_pc;
  assign fetch_fault     = fault_q;

  // Each redirect re-evaluates the flags, so an aligned one clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted  <= 1'b0;
      fault_q <= 1'b0;
    end else if (redirect_valid) begin
      halted  <= misalign;
      fault_q <= misalign;
    end
  end
`else
  assign misalign        = 1'b0;
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign halted          = 1'b0;
  assign fetch_fault     = 1'b0;
`endif

  assign unused_bits = ^{redirect_pc[1:0], fifo_full, misalign};

  assign pop = out_valid & out_ready;

  // Credit: entries buffered plus the word in flight, minus the one leaving now,
  // must leave room for the word this issue will return.
  assign credit_used = UW'(fifo_count) + UW'(inflight_v) - UW'(pop);
  assign issue = ~redirect_valid & ~halted & (credit_used < UW'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      inflight_v  <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q       <= redirect_target;
      inflight_v <= 1'b0;
    end else if (issue) begin
      pc_q        <= pc_q + 32'd4;
      inflight_v  <= 1'b1;
      inflight_pc <= pc_q;
    end else begin
      inflight_v <= 1'b0;
    end
  end

  // ce stays high in the capture cycle so the memory keeps driving q.
  assign imem_ce   = rst_n & (issue | inflight_v);
  assign imem_we   = 1'b0;
  assign imem_d    = '0;
  assign imem_addr = word_index(pc_q);

  assign push       = inflight_v & ~redirect_valid;
  assign push_entry = '{pc: inflight_pc, instr: imem_q};

  fetch_fifo #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .data  (push_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .count (fifo_count),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_pc    = head.pc;
  assign out_instr = fifo_empty ? INSTR_NOP : head.instr;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_ce;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_d;
  logic [31:0] imem_q;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_fault;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem [0:1023];
  logic [31:0] addr_reg;

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 32'hA000_0000 + k;
  end

  always @(posedge clk) if (imem_ce) addr_reg <= imem_addr;
  assign imem_q = imem_ce ? mem[addr_reg[9:0]] : 32'hzzzz_zzzz;

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_ce        (imem_ce),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_d         (imem_d),
    .imem_q         (imem_q),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_fault    (fetch_fault)
  );

  // Contents the preloaded memory holds at a byte PC.
  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return 32'hA000_0000 + {22'b0, pc[11:2]};
  endfunction

  // Cycle start is 1 time unit after the rising edge; sampling happens 4 later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    #4;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests++; if (imem_ce !== 1'b0) begin fails++; $display("FAIL reset_ce got %b exp 0", imem_ce); end
    tests++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %b exp 0", fetch_fault); end
    tests++; if (imem_we !== 1'b0 || imem_d !== 32'h0) begin fails++; $display("FAIL reset_we_d got %b/%h exp 0/0", imem_we, imem_d); end
    next_cycle();
  endtask

  // T1: release with out_ready=1, first word in cycle 2, then one per cycle.
  task automatic test_stream();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #4;
      if (c == 0) begin
        tests++; if (imem_ce !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL t1_first_issue got ce=%b addr=%h exp 1/0", imem_ce, imem_addr); end
      end
      if (c < 2) begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t1_early_valid c=%0d got %b exp 0", c, out_valid); end
      end else begin
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'(4 * (c - 2)) || out_instr !== 32'hA000_0000 + 32'(c - 2)) begin
          fails++; $display("FAIL t1_stream c=%0d got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                            c, out_valid, out_pc, out_instr, 32'(4 * (c - 2)), 32'hA000_0000 + 32'(c - 2));
        end
      end
      next_cycle();
    end
  endtask

  // T2: stall from reset; buffer fills, memory goes idle, head holds.
  task automatic test_stall();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      #4;
      if (c == 2 || c == 9) begin
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hA000_0000) begin
          fails++; $display("FAIL t2_hold c=%0d got v=%b pc=%h instr=%h exp 1/0/A0000000", c, out_valid, out_pc, out_instr);
        end
      end
      if (c == 9) begin
        tests++; if (imem_ce !== 1'b0) begin fails++; $display("FAIL t2_ce_idle got %b exp 0", imem_ce); end
      end
      next_cycle();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #4;
      tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * c) || out_instr !== exp_instr(32'(4 * c))) begin
        fails++; $display("FAIL t2_resume c=%0d got v=%b pc=%h instr=%h exp pc=%h", c, out_valid, out_pc, out_instr, 32'(4 * c));
      end
      next_cycle();
    end
  endtask

  // T3: redirect mid-stream; gap of two cycles, new stream in R+3.
  task automatic test_redirect();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #4;
    next_cycle();
    redirect_valid = 1'b0;
    for (int c = 1; c < 8; c++) begin
      #4;
      if (c < 3) begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t3_gap c=%0d got %b exp 0", c, out_valid); end
      end else begin
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40 + 32'(4 * (c - 3)) || out_instr !== exp_instr(32'h40 + 32'(4 * (c - 3)))) begin
          fails++; $display("FAIL t3_new c=%0d got v=%b pc=%h instr=%h exp pc=%h", c, out_valid, out_pc, out_instr, 32'h40 + 32'(4 * (c - 3)));
        end
      end
      next_cycle();
    end
  endtask

  // T4: two redirects on consecutive cycles; the second wins.
  task automatic test_back_to_back();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    next_cycle();
    redirect_pc = 32'hC0;
    next_cycle();
    redirect_valid = 1'b0;
    for (int c = 2; c < 9; c++) begin
      #4;
      if (c < 4) begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t4_gap c=%0d got %b exp 0", c, out_valid); end
      end else begin
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'hC0 + 32'(4 * (c - 4)) || out_instr !== exp_instr(32'hC0 + 32'(4 * (c - 4)))) begin
          fails++; $display("FAIL t4_last_wins c=%0d got v=%b pc=%h instr=%h exp pc=%h", c, out_valid, out_pc, out_instr, 32'hC0 + 32'(4 * (c - 4)));
        end
      end
      next_cycle();
    end
  endtask

  // T5: misaligned redirect.
  task automatic test_misalign();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    next_cycle();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    for (int c = 1; c < 6; c++) begin
      #4;
      tests++;
      if (fetch_fault !== 1'b1 || imem_ce !== 1'b0 || out_valid !== 1'b0) begin
        fails++; $display("FAIL t5_halted c=%0d got fault=%b ce=%b v=%b exp 1/0/0", c, fetch_fault, imem_ce, out_valid);
      end
      next_cycle();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    next_cycle();
    redirect_valid = 1'b0;
    for (int c = 1; c < 5; c++) begin
      #4;
      tests++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL t5_fault_clear c=%0d got %b exp 0", c, fetch_fault); end
      if (c == 3 || c == 4) begin
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * (c - 3)) || out_instr !== exp_instr(32'h100 + 32'(4 * (c - 3)))) begin
          fails++; $display("FAIL t5_restart c=%0d got v=%b pc=%h instr=%h exp pc=%h", c, out_valid, out_pc, out_instr, 32'h100 + 32'(4 * (c - 3)));
        end
      end
      next_cycle();
    end
`else
    for (int c = 1; c < 5; c++) begin
      #4;
      tests++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL t5_no_fault c=%0d got %b exp 0", c, fetch_fault); end
      if (c == 3 || c == 4) begin
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40 + 32'(4 * (c - 3)) || out_instr !== exp_instr(32'h40 + 32'(4 * (c - 3)))) begin
          fails++; $display("FAIL t5_forced_align c=%0d got v=%b pc=%h instr=%h exp pc=%h", c, out_valid, out_pc, out_instr, 32'h40 + 32'(4 * (c - 3)));
        end
      end
      next_cycle();
    end
`endif
  endtask

  // T6: asynchronous reset pulse with the buffer full.
  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || imem_ce !== 1'b0 || fetch_fault !== 1'b0) begin
      fails++; $display("FAIL t6_async_clear got v=%b ce=%b fault=%b exp 0/0/0", out_valid, imem_ce, fetch_fault);
    end
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #4;
      if (c < 2) begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t6_early c=%0d got %b exp 0", c, out_valid); end
      end else begin
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'(4 * (c - 2)) || out_instr !== exp_instr(32'(4 * (c - 2)))) begin
          fails++; $display("FAIL t6_refetch c=%0d got v=%b pc=%h instr=%h exp pc=%h", c, out_valid, out_pc, out_instr, 32'(4 * (c - 2)));
        end
      end
      next_cycle();
    end
  endtask

  // Random ready/redirect traffic against a stream model: after reset or a
  // redirect to P the stage must deliver P, P+4, ... in order, each head
  // showing the memory word for its PC, with no output for two cycles after
  // any redirect.
  task automatic test_random();
    logic [31:0] gen_pc;
    logic [63:0] exp_e;
    logic        rv;
    int          since_redir;
    int          accepts;
    do_reset();
    exp_q.delete();
    gen_pc = 32'h0;
    since_redir = 99;
    accepts = 0;
    for (int c = 0; c < 500; c++) begin
      while (exp_q.size() < 8) begin
        exp_q.push_back({gen_pc, exp_instr(gen_pc)});
        gen_pc = gen_pc + 32'd4;
      end
      rv = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = rv;
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      #4;
      if (since_redir == 1 || since_redir == 2) begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rnd_gap c=%0d got %b exp 0", c, out_valid); end
      end else if (out_valid === 1'b1) begin
        exp_e = exp_q[0];
        tests++;
        if ({out_pc, out_instr} !== exp_e) begin
          fails++; $display("FAIL rnd_head c=%0d got pc=%h instr=%h exp pc=%h instr=%h", c, out_pc, out_instr, exp_e[63:32], exp_e[31:0]);
        end
        if (out_ready && !rv) begin
          void'(exp_q.pop_front());
          accepts++;
        end
      end
      if (rv) begin
        exp_q.delete();
        gen_pc = redirect_pc;
        since_redir = 0;
      end
      since_redir++;
      next_cycle();
    end
    redirect_valid = 1'b0;
    tests++;
    if (accepts < 150) begin fails++; $display("FAIL rnd_throughput got %0d exp >=150", accepts); end
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    next_cycle();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
